// File: rtl/axis_frame_stats_pkg.sv
// Shared types and default widths for the AXI-Stream frame statistics block.
// Optional frame checksum: AXIS_FRAME_STATS_CHECKSUM_EN.
`timescale 1ns/1ps
package axis_frame_stats_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_USER_W = 1;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/axis_frame_stats_slice.sv
// Reusable one-deep AXI-Stream register slice, latency 1.
// Payload passes unmodified; ready follows the downstream when full.
`timescale 1ns/1ps
module axis_reg_slice #(
  parameter int DATA_W = 32,
  parameter int USER_W = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] s_tdata_i,
  input  logic              s_tkeep_i,
  input  logic              s_tvalid_i,
  input  logic              s_tlast_i,
  input  logic [USER_W-1:0] s_tuser_i,
  output logic              s_tready_o,
  output logic [DATA_W-1:0] m_tdata_o,
  output logic              m_tkeep_o,
  output logic              m_tvalid_o,
  output logic              m_tlast_o,
  output logic [USER_W-1:0] m_tuser_o,
  input  logic              m_tready_i
);

  logic [DATA_W-1:0] data_q;
  logic [USER_W-1:0] user_q;
  logic              keep_q;
  logic              last_q;
  logic              valid_q;
  logic              s_hs;

  assign s_tready_o = m_tready_i | ~valid_q;
  assign s_hs       = s_tvalid_i & s_tready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      user_q  <= '0;
      keep_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (s_hs) begin
        valid_q <= 1'b1;
        data_q  <= s_tdata_i;
        user_q  <= s_tuser_i;
        keep_q  <= s_tkeep_i;
        last_q  <= s_tlast_i;
      end else if (m_tready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign m_tvalid_o = valid_q;
  assign m_tdata_o  = data_q;
  assign m_tkeep_o  = keep_q;
  assign m_tlast_o  = last_q;
  assign m_tuser_o  = user_q;

endmodule

// File: rtl/axis_frame_stats.sv
// Video frame statistics on a pass-through AXI-Stream (tuser[0]=SOF, tlast=EOL).
// Define AXIS_FRAME_STATS_CHECKSUM_EN to add the per-frame XOR checksum output.
`timescale 1ns/1ps
module axis_frame_stats
  import axis_frame_stats_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = DEF_DATA_W,
  parameter int AXIS_USER_WIDTH = DEF_USER_W,
  parameter int CNT_WIDTH       = DEF_CNT_W
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,
  output logic                       s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tkeep,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  output logic [AXIS_USER_WIDTH-1:0] m_axis_tuser,
  input  logic                       m_axis_tready,
  output logic [CNT_WIDTH-1:0]       line_pixels,
  output logic [CNT_WIDTH-1:0]       frame_lines,
  output logic [31:0]                frame_count,
  output logic                       stat_valid,
  output logic                       err_line_len,
  output logic                       err_sof_midline,
`ifdef AXIS_FRAME_STATS_CHECKSUM_EN
  output logic [AXIS_DATA_WIDTH-1:0] frame_checksum,
`endif
  input  logic                       err_clear
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  axis_reg_slice #(
    .DATA_W (AXIS_DATA_WIDTH),
    .USER_W (AXIS_USER_WIDTH)
  ) u_slice (
    .clk_i      (aclk),
    .rst_i      (areset),
    .s_tdata_i  (s_axis_tdata),
    .s_tkeep_i  (s_axis_tkeep),
    .s_tvalid_i (s_axis_tvalid),
    .s_tlast_i  (s_axis_tlast),
    .s_tuser_i  (s_axis_tuser),
    .s_tready_o (s_axis_tready),
    .m_tdata_o  (m_axis_tdata),
    .m_tkeep_o  (m_axis_tkeep),
    .m_tvalid_o (m_axis_tvalid),
    .m_tlast_o  (m_axis_tlast),
    .m_tuser_o  (m_axis_tuser),
    .m_tready_i (m_axis_tready)
  );

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] pix_q, pix_d;
  logic [CNT_WIDTH-1:0] line_q, line_d;
  logic [CNT_WIDTH-1:0] ref_q, ref_d;
  logic [CNT_WIDTH-1:0] lp_q, lp_d;
  logic [CNT_WIDTH-1:0] fl_q, fl_d;
  logic [31:0]          fc_q, fc_d;
  logic                 stat_q, stat_d;
  logic                 elen_q, elen_d;
  logic                 esof_q, esof_d;
`ifdef AXIS_FRAME_STATS_CHECKSUM_EN
  logic [AXIS_DATA_WIDTH-1:0] csum_q, csum_d;
  logic [AXIS_DATA_WIDTH-1:0] fcs_q, fcs_d;
`endif

  logic                 hs;
  logic                 sof;
  logic [CNT_WIDTH-1:0] pix_inc;
  logic [CNT_WIDTH-1:0] line_inc;

  assign hs       = s_axis_tvalid & s_axis_tready;
  assign sof      = s_axis_tuser[0];
  assign pix_inc  = (pix_q == CNT_MAX) ? pix_q : pix_q + 1'b1;
  assign line_inc = (line_q == CNT_MAX) ? line_q : line_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    line_d  = line_q;
    ref_d   = ref_q;
    lp_d    = lp_q;
    fl_d    = fl_q;
    fc_d    = fc_q;
    stat_d  = 1'b0;
    elen_d  = elen_q & ~err_clear;
    esof_d  = esof_q & ~err_clear;
`ifdef AXIS_FRAME_STATS_CHECKSUM_EN
    csum_d  = csum_q;
    fcs_d   = fcs_q;
`endif
    if (hs && sof) begin
      // pix_q==0 in ACTIVE means the SOF lands on a line boundary
      if (state_q == ACTIVE) begin
        if (pix_q == '0) begin
          lp_d   = ref_q;
          fl_d   = line_q;
          fc_d   = fc_q + 32'd1;
          stat_d = 1'b1;
`ifdef AXIS_FRAME_STATS_CHECKSUM_EN
          fcs_d  = csum_q;
`endif
        end else begin
          esof_d = 1'b1;
        end
      end
      state_d = ACTIVE;
      pix_d   = CNT_ONE;
      line_d  = '0;
`ifdef AXIS_FRAME_STATS_CHECKSUM_EN
      csum_d  = s_axis_tdata;
`endif
      if (s_axis_tlast) begin
        line_d = CNT_ONE;
        ref_d  = CNT_ONE;
        pix_d  = '0;
      end
    end else if (hs && state_q == ACTIVE) begin
`ifdef AXIS_FRAME_STATS_CHECKSUM_EN
      csum_d = csum_q ^ s_axis_tdata;
`endif
      if (s_axis_tlast) begin
        line_d = line_inc;
        if (line_q == '0) begin
          ref_d = pix_inc;
        end else if (pix_inc != ref_q) begin
          elen_d = 1'b1;
        end
        pix_d = '0;
      end else begin
        pix_d = pix_inc;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= WAIT_SOF;
      pix_q   <= '0;
      line_q  <= '0;
      ref_q   <= '0;
      lp_q    <= '0;
      fl_q    <= '0;
      fc_q    <= '0;
      stat_q  <= 1'b0;
      elen_q  <= 1'b0;
      esof_q  <= 1'b0;
`ifdef AXIS_FRAME_STATS_CHECKSUM_EN
      csum_q  <= '0;
      fcs_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      ref_q   <= ref_d;
      lp_q    <= lp_d;
      fl_q    <= fl_d;
      fc_q    <= fc_d;
      stat_q  <= stat_d;
      elen_q  <= elen_d;
      esof_q  <= esof_d;
`ifdef AXIS_FRAME_STATS_CHECKSUM_EN
      csum_q  <= csum_d;
      fcs_q   <= fcs_d;
`endif
    end
  end

  assign line_pixels     = lp_q;
  assign frame_lines     = fl_q;
  assign frame_count     = fc_q;
  assign stat_valid      = stat_q;
  assign err_line_len    = elen_q;
  assign err_sof_midline = esof_q;
`ifdef AXIS_FRAME_STATS_CHECKSUM_EN
  assign frame_checksum  = fcs_q;
`endif

endmodule

// File: tb/tb_axis_frame_stats.sv
// Scoreboard bench for axis_frame_stats: frame-level reference model,
// randomized frames and backpressure, decoupled data and statistics monitors.
`timescale 1ns/1ps
module tb_axis_frame_stats;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_tdata;
  logic        s_tkeep, s_tvalid, s_tlast;
  logic [0:0]  s_tuser;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tkeep, m_tvalid, m_tlast;
  logic [0:0]  m_tuser;
  logic        m_tready;
  logic [15:0] line_pixels, frame_lines;
  logic [31:0] frame_count;
  logic        stat_valid, err_len, err_sof, err_clear;
`ifdef AXIS_FRAME_STATS_CHECKSUM_EN
  logic [31:0] frame_checksum;
`endif

  always #5 aclk = ~aclk;

  axis_frame_stats dut (
    .aclk            (aclk),
    .areset          (areset),
    .s_axis_tdata    (s_tdata),
    .s_axis_tkeep    (s_tkeep),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tlast    (s_tlast),
    .s_axis_tuser    (s_tuser),
    .s_axis_tready   (s_tready),
    .m_axis_tdata    (m_tdata),
    .m_axis_tkeep    (m_tkeep),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tlast    (m_tlast),
    .m_axis_tuser    (m_tuser),
    .m_axis_tready   (m_tready),
    .line_pixels     (line_pixels),
    .frame_lines     (frame_lines),
    .frame_count     (frame_count),
    .stat_valid      (stat_valid),
    .err_line_len    (err_len),
    .err_sof_midline (err_sof),
`ifdef AXIS_FRAME_STATS_CHECKSUM_EN
    .frame_checksum  (frame_checksum),
`endif
    .err_clear       (err_clear)
  );

  typedef struct {
    logic [31:0] d;
    logic        k, u, l;
  } beat_t;

  typedef struct {
    int          lp, fl;
    logic [31:0] fc, cs;
  } stat_t;

  beat_t dq[$];
  stat_t sq[$];
  stat_t pend;
  bit    in_frame, pend_ok, m_err_len, m_err_sof;
  int    fcnt, stat_seen, bp_mode, cyc;
  int    ln[$];
  int    n_vec = 0;
  int    n_mis = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  always @(posedge aclk) begin
    cyc = cyc + 1;
    #1;
    case (bp_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ($urandom % 3) != 0;
      default: m_tready = (cyc % 60) >= 10;
    endcase
  end

  always @(negedge aclk) begin
    beat_t b;
    if (!areset && m_tvalid && m_tready) begin
      if (dq.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        b = dq.pop_front();
        chk("tdata", m_tdata, b.d);
        chk("keep_last_user", {m_tkeep, m_tlast, m_tuser}, {b.k, b.l, b.u});
      end
    end
  end

  always @(negedge aclk) begin
    stat_t s;
    if (!areset && stat_valid) begin
      stat_seen = stat_seen + 1;
      if (sq.size() == 0) chk("unexpected_stat_valid", 1, 0);
      else begin
        s = sq.pop_front();
        chk("line_pixels", line_pixels, s.lp);
        chk("frame_lines", frame_lines, s.fl);
        chk("frame_count", frame_count, s.fc);
`ifdef AXIS_FRAME_STATS_CHECKSUM_EN
        chk("frame_checksum", frame_checksum, s.cs);
`endif
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic u, l, clr);
    int    t = 0;
    beat_t b;
    s_tdata  = d;
    s_tkeep  = 1'($urandom);
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    err_clear = clr;
    b.d = d; b.k = s_tkeep; b.u = u; b.l = l;
    do begin
      @(negedge aclk);
      t++;
    end while (!s_tready && t < 200);
    if (s_tready) dq.push_back(b);
    else chk("handshake_timeout", 0, 1);
    @(posedge aclk);
    #1;
    s_tvalid  = 1'b0;
    err_clear = 1'b0;
  endtask

  // A new SOF closes the previous frame if it ended on a line boundary
  function automatic void model_start();
    if (in_frame) begin
      if (pend_ok) begin
        fcnt++;
        pend.fc = fcnt;
        sq.push_back(pend);
      end else begin
        m_err_sof = 1'b1;
      end
    end
    in_frame = 1'b1;
    pend_ok  = 1'b0;
  endfunction

  task automatic send_frame(input int trunc, gap, input bit pat, clr_bad);
    logic [31:0] xr = '0;
    logic [31:0] d;
    bit          bad, c;
    model_start();
    for (int i = 0; i < ln.size(); i++) begin
      bad = (i > 0) && (ln[i] != ln[0]);
      for (int p = 0; p < ln[i]; p++) begin
        d = pat ? (32'd1 << (p % 4)) : $urandom;
        c = clr_bad && bad && (p == ln[i] - 1);
        if (c) m_err_sof = 1'b0;
        send_beat(d, (i == 0 && p == 0), (p == ln[i] - 1), c);
        xr ^= d;
      end
      if (bad) m_err_len = 1'b1;
      if (gap > 0) idle(gap);
    end
    for (int p = 0; p < trunc; p++) begin
      d = pat ? (32'd1 << (p % 4)) : $urandom;
      send_beat(d, (ln.size() == 0 && p == 0), 1'b0, 1'b0);
      xr ^= d;
    end
    pend_ok = (trunc == 0) && (ln.size() > 0);
    if (pend_ok) pend = '{lp: ln[0], fl: ln.size(), fc: 0, cs: xr};
  endtask

  task automatic check_flags();
    chk("err_line_len", err_len, m_err_len);
    chk("err_sof_midline", err_sof, m_err_sof);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    m_err_len = 1'b0;
    m_err_sof = 1'b0;
    idle(1);
    check_flags();
  endtask

  task automatic check_reset_outputs();
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_line_pixels", line_pixels, 0);
    chk("rst_frame_lines", frame_lines, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_stat_valid", stat_valid, 0);
    chk("rst_errors", {err_len, err_sof}, 0);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    dq.delete();
    sq.delete();
    in_frame = 0; pend_ok = 0; fcnt = 0;
    m_err_len = 0; m_err_sof = 0; stat_seen = 0;
    @(negedge aclk);
    check_reset_outputs();
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic close_frame();
    ln = '{1};
    send_frame(0, 2, 0, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, l0, tr;
    cyc = 0; bp_mode = 0; m_tready = 1'b1;
    s_tvalid = 0; s_tdata = 0; s_tkeep = 0; s_tlast = 0; s_tuser = 0;
    err_clear = 0;
    areset = 1'b1;
    idle(2);
    do_reset();
    idle(2);

    ln = '{20, 20, 20};
    send_frame(0, 5, 0, 0);
    close_frame();
    idle(5);
    check_flags();
    chk("s1_frame_count", frame_count, 1);
    chk("s1_line_pixels", line_pixels, 20);
    chk("s1_frame_lines", frame_lines, 3);

    bp_mode = 2;
    ln = '{20, 20, 20};
    send_frame(0, 5, 0, 0);
    close_frame();
    idle(25);
    check_flags();
    chk("s2_frame_lines", frame_lines, 3);
    bp_mode = 0;

    ln = '{20, 19, 20};
    send_frame(0, 5, 0, 1);
    idle(3);
    chk("s3_err_line_len_set", err_len, 1);
    pulse_clear();
    close_frame();
    idle(3);

    ln = '{20};
    send_frame(9, 0, 0, 0);
    ln = '{20, 20, 20};
    send_frame(0, 5, 0, 0);
    idle(3);
    chk("s4_err_sof_midline", err_sof, 1);
    close_frame();
    idle(5);
    check_flags();
    chk("s4_line_pixels", line_pixels, 20);
    chk("s4_frame_lines", frame_lines, 3);
    pulse_clear();

    bp_mode = 2;
    ln = '{20};
    send_frame(10, 0, 0, 0);
    do_reset();
    bp_mode = 0;
    for (int j = 0; j < 5; j++) send_beat($urandom, 1'b0, 1'(j == 2), 1'b0);
    ln = '{20, 20, 20};
    send_frame(0, 2, 0, 0);
    idle(10);
    chk("s5_no_stat_before_2nd_sof", stat_seen, 0);
    close_frame();
    idle(5);
    chk("s5_stat_after_2nd_sof", stat_seen, 1);
    chk("s5_frame_count", frame_count, 1);

    ln = '{4, 4};
    send_frame(0, 1, 1, 0);
    ln = '{4, 1};
    send_frame(0, 1, 1, 0);
    close_frame();
    idle(5);
`ifdef AXIS_FRAME_STATS_CHECKSUM_EN
    chk("cs_frame_checksum", frame_checksum, 32'h0000000E);
`endif
    pulse_clear();

    for (int f = 0; f < 30; f++) begin
      bp_mode = $urandom_range(0, 2);
      nl = $urandom_range(1, 4);
      l0 = $urandom_range(1, 8);
      ln.delete();
      for (int i = 0; i < nl; i++)
        ln.push_back(($urandom % 5 == 0) ? int'($urandom_range(1, 8)) : l0);
      tr = ($urandom % 6 == 0) ? int'($urandom_range(1, 8)) : 0;
      send_frame(tr, $urandom_range(0, 2), 1'($urandom), 1'b0);
      idle(3);
      check_flags();
      if ($urandom % 5 == 0) pulse_clear();
    end

    bp_mode = 0;
    close_frame();
    idle(30);
    chk("stat_queue_drained", sq.size(), 0);
    chk("data_queue_drained", dq.size(), 0);
    check_flags();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/axis_frame_stats.md
AXIS_FRAME_STATS -- requirements
Module: axis_frame_stats

Interface
REQ-001 The parameters SHALL be:
- AXIS_DATA_WIDTH, 32, tdata width
- AXIS_USER_WIDTH, 1, tuser width; bit 0 = start of frame (SOF)
- CNT_WIDTH, 16, width of the pixel and line counters
REQ-002 The ports SHALL be:
- aclk  in  1  the only clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- s_axis_tdata/tkeep/tvalid/tlast/tuser  in  AXIS_DATA_WIDTH/1/1/1/AXIS_USER_WIDTH  video stream from the cameralink receiver (tlast = end of line)
- s_axis_tready  out  1  upstream backpressure
- m_axis_tdata/tkeep/tvalid/tlast/tuser  out  same widths  pass-through stream
- m_axis_tready  in  1  downstream backpressure
- line_pixels  out  CNT_WIDTH  pixels per line of the last complete frame
- frame_lines  out  CNT_WIDTH  lines in the last complete frame
- frame_count  out  32  number of complete frames
- stat_valid  out  1  one-cycle pulse when the statistics outputs update
- err_line_len  out  1  sticky: a line length differed from the first line of its frame
- err_sof_midline  out  1  sticky: SOF arrived inside a line
- err_clear  in  1  clears both sticky errors

Function
REQ-003 The data path SHALL be one register slice with latency 1: s_axis_tready = m_axis_tready OR NOT m_axis_tvalid, and payload is passed unmodified.
REQ-004 A beat SHALL count only on an s_axis handshake (tvalid AND tready); stalls SHALL NOT change any counter.
REQ-005 The FSM SHALL have the states WAIT_SOF and ACTIVE.
- WAIT_SOF: beats pass through uncounted.
- A beat with tuser[0] SHALL move the FSM to ACTIVE, with pix_cnt=1 and line_cnt=0.
REQ-006 In ACTIVE, each beat SHALL increment pix_cnt.
REQ-007 On a tlast beat, the block SHALL complete the line:
- line_cnt increments;
- on the first line, ref_len is set to pix_cnt;
- on later lines, pix_cnt not equal to ref_len sets err_line_len;
- pix_cnt then clears.
REQ-008 A tuser beat in ACTIVE with pix_cnt=0 (line boundary) SHALL close the previous frame:
- line_pixels takes ref_len and frame_lines takes line_cnt;
- frame_count increments and stat_valid pulses in the next cycle;
- new frame counting starts on that beat.
REQ-009 A tuser beat with pix_cnt not equal to 0 SHALL:
- set err_sof_midline;
- discard the partial frame (no stat_valid);
- restart counting on that beat.
REQ-010 A beat with both tuser and tlast SHALL count as a one-pixel line that opens a new frame.
REQ-011 pix_cnt and line_cnt SHALL saturate at all-ones; frame_count SHALL wrap.
REQ-012 When err_clear coincides with a new error event, the error SHALL win (the flag stays set).

Reset
REQ-013 When areset is asserted, the block SHALL:
- set m_axis_tvalid=0, all counters 0, line_pixels, frame_lines and frame_count 0, stat_valid 0, and both error flags 0;
- put the FSM in WAIT_SOF;
- drop any in-flight beat.
REQ-014 After reset is released mid-frame, no statistics SHALL be reported until the next SOF.

Configuration
REQ-015 With AXIS_FRAME_STATS_CHECKSUM_EN defined, the block SHALL:
- add the output frame_checksum (AXIS_DATA_WIDTH), the XOR of all tdata of the last complete frame;
- update frame_checksum together with stat_valid;
- reset frame_checksum to 0.
REQ-016 Without AXIS_FRAME_STATS_CHECKSUM_EN, the port and the logic SHALL be absent.

Structure
REQ-017 A shared package SHALL hold the FSM state typedef and the default width constants.
REQ-018 The register slice SHALL be the sub-module axis_reg_slice, so it can be reused.

Verification
REQ-019 The bench SHALL cover these scenarios:
- 3 lines of 20 pixels (5-cycle gaps), then SOF -> stat_valid once, line_pixels=20, frame_lines=3, frame_count=1, no errors.
- Same stream, m_axis_tready low for 100 ns every 600 ns -> output beat sequence identical to input, stats unchanged.
- Second line 19 pixels -> err_line_len=1 at the tlast beat; err_clear then drops it to 0.
- SOF at pixel 10 of line 2 -> err_sof_midline=1, no stat_valid for that frame; the next clean frame reports 20/3.
- areset pulse mid-line 2 -> outputs 0 and m_axis_tvalid=0; no stat_valid before two SOFs are seen.
- With AXIS_FRAME_STATS_CHECKSUM_EN: 2 lines of pixels 0x01, 0x02, 0x04, 0x08 -> frame_checksum=0x00000000; with 0x01 alone in line 2 -> 0x0000000E.
